// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared constants, attribute field positions, controller
// state encoding and the glyph-bit to palette-index helper for the
// character-cell pixel generator.
package vga_text_pkg;

   localparam int CHAR_W  = 8;
   localparam int GLYPH_H = 16;

   localparam int FG_LSB = 0;
   localparam int FG_MSB = 3;
   localparam int BG_LSB = 4;
   localparam int BG_MSB = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // A set glyph bit shows the foreground nibble, a clear one shows the
   // three background bits zero-extended. The blink/intensity bit 7 of the
   // attribute never reaches this function.
   function automatic logic [3:0] cellColor(input logic glyphBit, input logic [6:0] attr);
      if (glyphBit) begin
         return attr[FG_MSB:FG_LSB];
      end
      return {1'b0, attr[BG_MSB:BG_LSB]};
   endfunction

endpackage

// File: rtl/vga_text_shift.sv
// vga_text_shift: 8-bit glyph-row shifter with the attribute latched beside
// it and the palette mux on the output. A load always wins over a shift so
// the next cell can be dropped in on the last pixel of the current one.
// Optional cursor overlay when VGA_TEXT_CURSOR_EN is defined.
module vga_text_shift
   import vga_text_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] glyph_i,
   input  logic [6:0] attr_i,
`ifdef VGA_TEXT_CURSOR_EN
   input  logic       cursor_i,
`endif
   output logic       pixValid_o,
   output logic       lastPix_o,
   output logic [3:0] pixColor_o
);

   logic [7:0] shift_q;
   logic [6:0] attr_q;
   logic [3:0] left_q;
`ifdef VGA_TEXT_CURSOR_EN
   logic       cursor_q;
`endif

   // Load a fresh glyph row with its own attribute, otherwise shift out
   // one pixel per cycle until the row is exhausted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         attr_q  <= '0;
         left_q  <= '0;
      end else if (load_i) begin
         shift_q <= glyph_i;
         attr_q  <= attr_i;
         left_q  <= 4'(CHAR_W);
      end else if (left_q != 4'd0) begin
         shift_q <= {shift_q[6:0], 1'b0};
         left_q  <= left_q - 4'd1;
      end
   end

`ifdef VGA_TEXT_CURSOR_EN
   // The cursor flag travels with the glyph row it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cursor_q <= 1'b0;
      end else if (load_i) begin
         cursor_q <= cursor_i;
      end
   end
`endif

   assign pixValid_o = (left_q != 4'd0);
   assign lastPix_o  = (left_q == 4'd1);

   // Palette mux; the output is forced to 0 whenever no pixel is present.
   always_comb begin
      pixColor_o = 4'd0;
      if (left_q != 4'd0) begin
         pixColor_o = cellColor(shift_q[7], attr_q);
`ifdef VGA_TEXT_CURSOR_EN
         if (cursor_q) begin
            pixColor_o = attr_q[FG_MSB:FG_LSB];
         end
`endif
      end
   end

endmodule

// File: rtl/vga_text_pixgen.sv
// vga_text_pixgen: renders one scanline of COLS text cells. Each cell costs
// one video-RAM read and one character-ROM read, issued every 8 cycles so
// that the next cell is ready exactly when the current one runs out.
// Pipeline per cell: vram_rd (X), rom_cs (X+1), shifter load (X+2),
// pixels X+3..X+10. Cursor overlay is built only with VGA_TEXT_CURSOR_EN.
module vga_text_pixgen
   import vga_text_pkg::*;
#(
   parameter int          COLS      = 80,
   parameter logic [11:0] VRAM_BASE = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  crow,
   input  logic [3:0]  sl,
   output logic        vram_rd,
   output logic [11:0] vram_addr,
   input  logic [15:0] vram_data,
   output logic        rom_cs,
   output logic [11:0] rom_addr,
   input  logic [7:0]  rom_data,
   input  logic [11:0] cur_pos,
   input  logic [3:0]  cur_start,
   input  logic [3:0]  cur_end,
   output logic        pix_valid,
   output logic [3:0]  pix_color,
   output logic        busy
);

   localparam int              ColW    = $clog2(COLS + 1);
   localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
   localparam logic [11:0]     ColsW   = 12'(COLS);

   state_e          state_q, state_d;
   logic [ColW-1:0] col_q, col_d;
   logic [2:0]      phase_q, phase_d;
   logic [11:0]     addr_q, addr_d;
   logic [3:0]      sl_q, sl_d;
   logic            romCs_q;
   logic            load_q;
   logic [6:0]      attrPipe_q;
   logic            fetch;
   logic            lastFetch;
   logic            lastPix;
   logic [11:0]     lineBase;
   logic            unusedBits;

   assign lineBase  = VRAM_BASE + {7'd0, crow} * ColsW;
   assign lastFetch = (col_q == LastCol);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: FILL waits for the first row to reach the shifter, RUN
   // streams, DRAIN lets the final cell play out after the last fetch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = FILL;
         end
         FILL: begin
            if (fetch && lastFetch) state_d = DRAIN;
            else if (load_q)        state_d = RUN;
         end
         RUN: begin
            if (fetch && lastFetch) state_d = DRAIN;
         end
         DRAIN: begin
            if (!romCs_q && !load_q && lastPix) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state: a fetch slot opens on phase 0 while cells
   // remain, and busy covers everything but IDLE.
   always_comb begin
      fetch = 1'b0;
      busy  = 1'b0;
      if (state_q != IDLE) begin
         busy = 1'b1;
      end
      if ((state_q == FILL || state_q == RUN) && phase_q == 3'd0) begin
         fetch = 1'b1;
      end
   end

   // Line bookkeeping: a new line latches the row base and scanline,
   // afterwards the phase free-runs and each fetch advances the column.
   always_comb begin
      col_d   = col_q;
      phase_d = phase_q;
      addr_d  = addr_q;
      sl_d    = sl_q;
      if (state_q == IDLE) begin
         if (start) begin
            col_d   = '0;
            phase_d = 3'd0;
            addr_d  = lineBase;
            sl_d    = sl;
         end
      end else begin
         phase_d = phase_q + 3'd1;
         if (fetch) begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 12'd1;
         end
      end
   end

   // Counter and address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= '0;
         phase_q <= '0;
         addr_q  <= '0;
         sl_q    <= '0;
      end else begin
         col_q   <= col_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         sl_q    <= sl_d;
      end
   end

   // Fetch pipeline: the ROM is enabled the cycle VRAM data arrives, and the
   // attribute is held one cycle so it meets its glyph row at the shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         romCs_q    <= 1'b0;
         load_q     <= 1'b0;
         attrPipe_q <= '0;
      end else begin
         romCs_q <= fetch;
         load_q  <= romCs_q;
         if (romCs_q) begin
            attrPipe_q <= vram_data[14:8];
         end
      end
   end

   assign vram_rd   = fetch;
   assign vram_addr = addr_q;
   assign rom_cs    = romCs_q;
   assign rom_addr  = romCs_q ? {vram_data[7:0], sl_q} : 12'd0;

`ifdef VGA_TEXT_CURSOR_EN
   logic curHit;
   logic curHit1_q;
   logic curHit2_q;

   assign curHit = fetch && (addr_q == cur_pos) && (cur_start <= sl_q) && (sl_q <= cur_end);

   // Carry the cursor match down the same two stages as the glyph fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curHit1_q <= 1'b0;
         curHit2_q <= 1'b0;
      end else begin
         curHit1_q <= curHit;
         curHit2_q <= curHit1_q;
      end
   end

   assign unusedBits = vram_data[15];
`else
   assign unusedBits = ^{vram_data[15], cur_pos, cur_start, cur_end};
`endif

   vga_text_shift uShift (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_q),
      .glyph_i    (rom_data),
      .attr_i     (attrPipe_q),
`ifdef VGA_TEXT_CURSOR_EN
      .cursor_i   (curHit2_q),
`endif
      .pixValid_o (pix_valid),
      .lastPix_o  (lastPix),
      .pixColor_o (pix_color)
   );

endmodule
